// File: rtl/demux_striping_n.sv
// Round-robin word striper: packs a serial word stream into LANES-wide stripes
// with valid/ready backpressure, partial-stripe flush and a one-deep pending stripe.
module demux_striping_n #(
  parameter int               WIDTH    = 32,
  parameter int               LANES    = 4,
  parameter int               PTR_W    = $clog2(LANES),
  parameter logic [WIDTH-1:0] PAD_WORD = {WIDTH{1'b0}}
) (
  input  logic                   clk_2f,
  input  logic                   reset_L,
  input  logic [WIDTH-1:0]       data_in,
  input  logic                   valid_in,
  output logic                   ready_in,
  input  logic                   flush_in,
  output logic [LANES*WIDTH-1:0] lanes_out,
  output logic [LANES-1:0]       lane_mask_out,
  output logic                   valid_out,
  input  logic                   ready_out
);

  logic [WIDTH-1:0]       stage [LANES];
  logic [LANES-1:0]       smask;
  logic [PTR_W-1:0]       ptr;
  logic                   stage_full;
  logic [LANES*WIDTH-1:0] pend_lanes;
  logic [LANES-1:0]       pend_mask;

  logic                   acc;
  logic                   close;
  logic                   out_free;
  logic [LANES*WIDTH-1:0] close_lanes;
  logic [LANES-1:0]       close_mask;

  assign ready_in = reset_L & ~stage_full;
  assign acc      = valid_in & ready_in;
  assign out_free = ~valid_out | ready_out;
  assign close    = (acc && ptr == PTR_W'(LANES - 1)) ||
                    (flush_in && (ptr != '0 || acc));

  // Closed stripe as it would look including this cycle's accepted word.
  always_comb begin
    close_lanes = '0;
    close_mask  = '0;
    for (int k = 0; k < LANES; k++) begin
      close_mask[k] = smask[k] | (acc && ptr == PTR_W'(k));
      if (acc && ptr == PTR_W'(k))
        close_lanes[k*WIDTH +: WIDTH] = data_in;
      else if (smask[k])
        close_lanes[k*WIDTH +: WIDTH] = stage[k];
      else
        close_lanes[k*WIDTH +: WIDTH] = PAD_WORD;
    end
  end

  // Stage words are qualified by smask, so they need no reset.
  always_ff @(posedge clk_2f) begin
    if (acc)
      stage[ptr] <= data_in;
  end

  always_ff @(posedge clk_2f) begin
    if (!reset_L) begin
      ptr   <= '0;
      smask <= '0;
    end else if (close) begin
      ptr   <= '0;
      smask <= '0;
    end else if (acc) begin
      ptr        <= ptr + PTR_W'(1);
      smask[ptr] <= 1'b1;
    end
  end

  // A pending stripe always drains before a new close can occur: while
  // stage_full is set nothing is accepted and ptr stays at zero.
  always_ff @(posedge clk_2f) begin
    if (!reset_L) begin
      lanes_out     <= '0;
      lane_mask_out <= '0;
      valid_out     <= 1'b0;
      stage_full    <= 1'b0;
      pend_lanes    <= '0;
      pend_mask     <= '0;
    end else if (stage_full && out_free) begin
      lanes_out     <= pend_lanes;
      lane_mask_out <= pend_mask;
      valid_out     <= 1'b1;
      stage_full    <= 1'b0;
    end else if (close && out_free) begin
      lanes_out     <= close_lanes;
      lane_mask_out <= close_mask;
      valid_out     <= 1'b1;
    end else if (close) begin
      pend_lanes <= close_lanes;
      pend_mask  <= close_mask;
      stage_full <= 1'b1;
    end else if (ready_out) begin
      valid_out <= 1'b0;
    end
  end

endmodule

// File: tb/tb_demux_striping_n.sv
// Directed bench for demux_striping_n (WIDTH=32, LANES=4): full stripes,
// flushes, backpressure with pending stripe, and reset mid-stripe.
module tb_demux_striping_n;

  localparam int WIDTH = 32;
  localparam int LANES = 4;

  logic                   clk_2f = 1'b0;
  logic                   reset_L;
  logic [WIDTH-1:0]       data_in;
  logic                   valid_in;
  logic                   ready_in;
  logic                   flush_in;
  logic [LANES*WIDTH-1:0] lanes_out;
  logic [LANES-1:0]       lane_mask_out;
  logic                   valid_out;
  logic                   ready_out;

  int n_checks = 0;
  int n_errors = 0;

  demux_striping_n #(.WIDTH(WIDTH), .LANES(LANES)) dut (
    .clk_2f        (clk_2f),
    .reset_L       (reset_L),
    .data_in       (data_in),
    .valid_in      (valid_in),
    .ready_in      (ready_in),
    .flush_in      (flush_in),
    .lanes_out     (lanes_out),
    .lane_mask_out (lane_mask_out),
    .valid_out     (valid_out),
    .ready_out     (ready_out)
  );

  always #5 clk_2f = ~clk_2f;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Drive one cycle of input, then sample 1 time unit after the edge.
  task automatic step(input logic v, input logic [WIDTH-1:0] d, input logic f);
    valid_in = v;
    data_in  = d;
    flush_in = f;
    @(posedge clk_2f);
    #1;
    valid_in = 1'b0;
    flush_in = 1'b0;
  endtask

  function automatic logic [127:0] seq_stripe(input logic [31:0] base);
    return {base + 32'd3, base + 32'd2, base + 32'd1, base};
  endfunction

  int sent;
  int got_stripes;

  initial begin
    reset_L   = 1'b0;
    valid_in  = 1'b1;
    data_in   = 32'h55;
    flush_in  = 1'b0;
    ready_out = 1'b1;
    repeat (3) @(posedge clk_2f);
    #1;
    check("rst_valid", 128'(valid_out), 128'(0));
    check("rst_ready_in", 128'(ready_in), 128'(0));
    check("rst_lanes", lanes_out, 128'(0));
    check("rst_mask", 128'(lane_mask_out), 128'(0));
    reset_L  = 1'b1;
    valid_in = 1'b0;
    #1;
    check("ready_in_idle", 128'(ready_in), 128'(1));

    // Back-to-back full stripes at full rate
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 32'hA0 + 32'(i), 1'b0);
      check($sformatf("a_valid_%0d", i), 128'(valid_out), 128'((i == 3) || (i == 7)));
      if (i == 3) begin
        check("a_stripe0", lanes_out, seq_stripe(32'hA0));
        check("a_mask0", 128'(lane_mask_out), 128'(4'hF));
      end
      if (i == 7) begin
        check("a_stripe1", lanes_out, seq_stripe(32'hA4));
        check("a_mask1", 128'(lane_mask_out), 128'(4'hF));
      end
    end
    step(1'b0, 32'h0, 1'b0);
    check("a_drain", 128'(valid_out), 128'(0));

    // Flush alone after two words
    step(1'b1, 32'hB0, 1'b0);
    step(1'b1, 32'hB1, 1'b0);
    check("b_no_early", 128'(valid_out), 128'(0));
    step(1'b0, 32'h0, 1'b1);
    check("b_valid", 128'(valid_out), 128'(1));
    check("b_stripe", lanes_out, {32'h0, 32'h0, 32'hB1, 32'hB0});
    check("b_mask", 128'(lane_mask_out), 128'(4'b0011));
    step(1'b0, 32'h0, 1'b0);

    // Flush coincident with third word, then flush with empty stage
    step(1'b1, 32'hC0, 1'b0);
    step(1'b1, 32'hC1, 1'b0);
    step(1'b1, 32'hC2, 1'b1);
    check("c_valid", 128'(valid_out), 128'(1));
    check("c_stripe", lanes_out, {32'h0, 32'hC2, 32'hC1, 32'hC0});
    check("c_mask", 128'(lane_mask_out), 128'(4'b0111));
    step(1'b0, 32'h0, 1'b1);
    check("c_empty_flush", 128'(valid_out), 128'(0));
    step(1'b0, 32'h0, 1'b0);
    check("c_empty_flush2", 128'(valid_out), 128'(0));

    // Backpressure: output + pending stripe absorb 8 words, then stall
    ready_out = 1'b0;
    sent = 0;
    for (int c = 0; c < 12; c++) begin
      if (sent < 12 && ready_in) begin
        step(1'b1, 32'hD0 + 32'(sent), 1'b0);
        sent++;
      end else begin
        step(1'b0, 32'h0, 1'b0);
      end
    end
    check("d_words_taken", 128'(sent), 128'(8));
    check("d_ready_in_low", 128'(ready_in), 128'(0));
    check("d_valid_held", 128'(valid_out), 128'(1));
    check("d_lanes_held", lanes_out, seq_stripe(32'hD0));

    ready_out = 1'b1;
    got_stripes = 0;
    for (int c = 0; c < 40 && got_stripes < 3; c++) begin
      if (valid_out && ready_out) begin
        check($sformatf("d_stripe%0d", got_stripes), lanes_out,
              seq_stripe(32'hD0 + 32'(4 * got_stripes)));
        check($sformatf("d_mask%0d", got_stripes), 128'(lane_mask_out), 128'(4'hF));
        got_stripes++;
      end
      if (sent < 12 && ready_in) begin
        step(1'b1, 32'hD0 + 32'(sent), 1'b0);
        sent++;
      end else begin
        step(1'b0, 32'h0, 1'b0);
      end
    end
    check("d_stripe_count", 128'(got_stripes), 128'(3));
    step(1'b0, 32'h0, 1'b0);
    check("d_idle", 128'(valid_out), 128'(0));

    // Reset mid-stripe discards the partial stripe
    step(1'b1, 32'hE0, 1'b0);
    step(1'b1, 32'hE1, 1'b0);
    reset_L = 1'b0;
    step(1'b0, 32'h0, 1'b0);
    reset_L = 1'b1;
    check("e_no_stripe", 128'(valid_out), 128'(0));
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 32'hF0 + 32'(i), 1'b0);
      check($sformatf("e_valid_%0d", i), 128'(valid_out), 128'(i == 3));
    end
    check("e_stripe", lanes_out, seq_stripe(32'hF0));
    check("e_mask", 128'(lane_mask_out), 128'(4'hF));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
